// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART RX frame timer.
// Holds the phase and state encodings plus the frame-length calculation.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        PH_START  = 2'd0,
        PH_DATA   = 2'd1,
        PH_PARITY = 2'd2,
        PH_STOP   = 2'd3
    } phase_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned MIN_PRESCALE  = 4;
    localparam int unsigned MIN_DATA_BITS = 5;

    // Start bit + data bits + optional parity + one or two stop bits.
    function automatic int unsigned frameLength(input int unsigned dataBits,
                                                input logic        parityEn,
                                                input logic        twoStop);
        return 32'd1 + dataBits + {31'd0, parityEn} + (twoStop ? 32'd2 : 32'd1);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_latch.sv
// Clamps the run-time frame configuration and captures it on frame start.
// Stores derived values (last edge, mid edge, last bit) so the timer only compares.
module uart_rx_cfg_latch
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_MAX   = 32,
    parameter int DATA_WIDTH_MAX = 8,
    localparam int PW = $clog2(PRESCALE_MAX) + 1,
    localparam int EW = $clog2(PRESCALE_MAX),
    localparam int DW = $clog2(DATA_WIDTH_MAX + 1),
    localparam int BW = $clog2(DATA_WIDTH_MAX + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [PW-1:0] i_prescale,
    input  logic [DW-1:0] i_data_bits,
    input  logic          i_parity_en,
    input  logic          i_two_stop,
    output logic [EW-1:0] o_lastEdge,
    output logic [EW-1:0] o_midEdge,
    output logic [DW-1:0] o_dataBits,
    output logic          o_parityEn,
    output logic [BW-1:0] o_lastBit
);

    logic [PW-1:0] w_prescale;
    logic [DW-1:0] w_dataBits;
    int unsigned   w_frameLen;

    logic [EW-1:0] r_lastEdge;
    logic [EW-1:0] r_midEdge;
    logic [DW-1:0] r_dataBits;
    logic          r_parityEn;
    logic [BW-1:0] r_lastBit;

    always_comb begin
        w_prescale = i_prescale;
        if (i_prescale < PW'(MIN_PRESCALE)) begin
            w_prescale = PW'(MIN_PRESCALE);
        end else if (i_prescale > PW'(PRESCALE_MAX)) begin
            w_prescale = PW'(PRESCALE_MAX);
        end

        w_dataBits = i_data_bits;
        if (i_data_bits < DW'(MIN_DATA_BITS)) begin
            w_dataBits = DW'(MIN_DATA_BITS);
        end else if (i_data_bits > DW'(DATA_WIDTH_MAX)) begin
            w_dataBits = DW'(DATA_WIDTH_MAX);
        end
    end

    assign w_frameLen = frameLength(32'(w_dataBits), i_parity_en, i_two_stop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lastEdge <= '0;
            r_midEdge  <= '0;
            r_dataBits <= '0;
            r_parityEn <= 1'b0;
            r_lastBit  <= '0;
        end else if (i_load) begin
            r_lastEdge <= EW'(w_prescale - PW'(1));
            r_midEdge  <= EW'(w_prescale >> 1);
            r_dataBits <= w_dataBits;
            r_parityEn <= i_parity_en;
            r_lastBit  <= BW'(w_frameLen - 32'd1);
        end
    end

    assign o_lastEdge = r_lastEdge;
    assign o_midEdge  = r_midEdge;
    assign o_dataBits = r_dataBits;
    assign o_parityEn = r_parityEn;
    assign o_lastBit  = r_lastBit;

endmodule

// File: rtl/uart_rx_frame_timer.sv
// UART RX frame timer: counts oversample ticks per bit and bits per frame, decoding strobes and phase.
// Optional 3-point majority-vote strobe is enabled by defining UART_RX_FRAME_TIMER_MAJORITY_EN.
module uart_rx_frame_timer
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE_MAX   = 32,
    parameter int DATA_WIDTH_MAX = 8,
    localparam int PW = $clog2(PRESCALE_MAX) + 1,
    localparam int EW = $clog2(PRESCALE_MAX),
    localparam int DW = $clog2(DATA_WIDTH_MAX + 1),
    localparam int BW = $clog2(DATA_WIDTH_MAX + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [PW-1:0] i_prescale,
    input  logic [DW-1:0] i_data_bits,
    input  logic          i_parity_en,
    input  logic          i_two_stop,
    output logic          o_busy,
    output logic [EW-1:0] o_edge_count,
    output logic [BW-1:0] o_bit_count,
    output logic [1:0]    o_phase,
    output logic          o_sample_strobe,
    output logic          o_bit_done,
    output logic          o_frame_done
`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
    ,
    output logic          o_vote_strobe
`endif
);

    state_t        r_state;
    state_t        w_nextState;
    logic [EW-1:0] r_edgeCount;
    logic [EW-1:0] w_nextEdge;
    logic [BW-1:0] r_bitCount;
    logic [BW-1:0] w_nextBit;

    logic [EW-1:0] w_lastEdge;
    logic [EW-1:0] w_midEdge;
    logic [DW-1:0] w_dataBits;
    logic          w_parityEn;
    logic [BW-1:0] w_lastBit;

    logic          w_load;
    logic          w_active;
    logic          w_bitDone;
    logic          w_frameDone;
    phase_t        w_phase;

    // Abort beats start, so a simultaneous pair must not disturb the shadow config either.
    assign w_load = i_start & ~i_abort;

    uart_rx_cfg_latch #(
        .PRESCALE_MAX  (PRESCALE_MAX),
        .DATA_WIDTH_MAX(DATA_WIDTH_MAX)
    ) u_cfg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_prescale (i_prescale),
        .i_data_bits(i_data_bits),
        .i_parity_en(i_parity_en),
        .i_two_stop (i_two_stop),
        .o_lastEdge (w_lastEdge),
        .o_midEdge  (w_midEdge),
        .o_dataBits (w_dataBits),
        .o_parityEn (w_parityEn),
        .o_lastBit  (w_lastBit)
    );

    assign w_active    = (r_state == ST_RUN) & i_tick;
    assign w_bitDone   = w_active & (r_edgeCount == w_lastEdge);
    assign w_frameDone = w_bitDone & (r_bitCount == w_lastBit);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_edgeCount <= '0;
            r_bitCount  <= '0;
        end else begin
            r_state     <= w_nextState;
            r_edgeCount <= w_nextEdge;
            r_bitCount  <= w_nextBit;
        end
    end

    // Priority: abort, then (re)start, then the normal tick-driven count.
    always_comb begin
        w_nextState = r_state;
        w_nextEdge  = r_edgeCount;
        w_nextBit   = r_bitCount;
        if (i_abort) begin
            w_nextState = ST_IDLE;
            w_nextEdge  = '0;
            w_nextBit   = '0;
        end else if (i_start) begin
            w_nextState = ST_RUN;
            w_nextEdge  = '0;
            w_nextBit   = '0;
        end else if (w_active) begin
            if (w_frameDone) begin
                w_nextState = ST_IDLE;
                w_nextEdge  = '0;
                w_nextBit   = '0;
            end else if (w_bitDone) begin
                w_nextEdge  = '0;
                w_nextBit   = r_bitCount + BW'(1);
            end else begin
                w_nextEdge  = r_edgeCount + EW'(1);
            end
        end
    end

    always_comb begin
        w_phase = PH_STOP;
        if (r_bitCount == '0) begin
            w_phase = PH_START;
        end else if (r_bitCount <= BW'(w_dataBits)) begin
            w_phase = PH_DATA;
        end else if (w_parityEn && (r_bitCount == BW'(w_dataBits) + BW'(1))) begin
            w_phase = PH_PARITY;
        end
    end

    assign o_busy          = (r_state == ST_RUN);
    assign o_edge_count    = r_edgeCount;
    assign o_bit_count     = r_bitCount;
    assign o_phase         = w_phase;
    assign o_sample_strobe = w_active & (r_edgeCount == w_midEdge);
    assign o_bit_done      = w_bitDone;
    assign o_frame_done    = w_frameDone;

`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
    assign o_vote_strobe = w_active & ((r_edgeCount == w_midEdge - EW'(1)) |
                                       (r_edgeCount == w_midEdge) |
                                       (r_edgeCount == w_midEdge + EW'(1)));
`endif

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Scoreboard bench for uart_rx_frame_timer: stimulus pushes per-bit expectations, a monitor checks each bit_done.
// Also covers UART_RX_FRAME_TIMER_MAJORITY_EN when that macro is defined.
module tb_uart_rx_frame_timer;
    import uart_rx_pkg::*;

    logic       i_clk;
    logic       i_rst;
    logic       i_tick;
    logic       i_start;
    logic       i_abort;
    logic [5:0] i_prescale;
    logic [3:0] i_data_bits;
    logic       i_parity_en;
    logic       i_two_stop;
    logic       o_busy;
    logic [4:0] o_edge_count;
    logic [3:0] o_bit_count;
    logic [1:0] o_phase;
    logic       o_sample_strobe;
    logic       o_bit_done;
    logic       o_frame_done;
`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
    logic       o_vote_strobe;
`endif

    uart_rx_frame_timer #(
        .PRESCALE_MAX  (32),
        .DATA_WIDTH_MAX(8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_tick         (i_tick),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_prescale     (i_prescale),
        .i_data_bits    (i_data_bits),
        .i_parity_en    (i_parity_en),
        .i_two_stop     (i_two_stop),
        .o_busy         (o_busy),
        .o_edge_count   (o_edge_count),
        .o_bit_count    (o_bit_count),
        .o_phase        (o_phase),
        .o_sample_strobe(o_sample_strobe),
        .o_bit_done     (o_bit_done),
        .o_frame_done   (o_frame_done)
`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
        ,
        .o_vote_strobe  (o_vote_strobe)
`endif
    );

    typedef struct {
        int bitIdx;
        int phase;
        int frameDone;
        int lastEdge;
        int midEdge;
        int frameTicks;
    } exp_t;

    exp_t expQ[$];
    int   compared;
    int   mismatched;
    int   tickPeriod;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Tick generator: one tick every tickPeriod cycles, changed just after the clock edge.
    initial begin
        int cnt;
        cnt    = 0;
        i_tick = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            cnt++;
            i_tick = ((cnt % tickPeriod) == 0);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // Reference model: clamp, frame length and per-bit expectations.
    task automatic pushExpected(input int prescale, input int dataBits, input int parity,
                                input int twoStop, input int nBits);
        int p, d, len, lim;
        exp_t e;
        p   = (prescale < 4) ? 4 : ((prescale > 32) ? 32 : prescale);
        d   = (dataBits < 5) ? 5 : ((dataBits > 8) ? 8 : dataBits);
        len = 1 + d + parity + (twoStop != 0 ? 2 : 1);
        lim = (nBits < 0) ? len : nBits;
        for (int b = 0; b < lim; b++) begin
            e.bitIdx     = b;
            if (b == 0)                          e.phase = int'(PH_START);
            else if (b <= d)                     e.phase = int'(PH_DATA);
            else if (b == d + 1 && parity != 0)  e.phase = int'(PH_PARITY);
            else                                 e.phase = int'(PH_STOP);
            e.frameDone  = (b == len - 1) ? 1 : 0;
            e.lastEdge   = p - 1;
            e.midEdge    = p / 2;
            e.frameTicks = p * len;
            expQ.push_back(e);
        end
    endtask

    // Configuration inputs are scrambled right after start to show they are not re-sampled.
    task automatic pulseStart(input int prescale, input int dataBits, input int parity, input int twoStop);
        i_prescale  = 6'(prescale);
        i_data_bits = 4'(dataBits);
        i_parity_en = 1'(parity);
        i_two_stop  = 1'(twoStop);
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
        i_prescale  = 6'd5;
        i_data_bits = 4'd6;
        i_parity_en = ~i_parity_en;
        i_two_stop  = ~i_two_stop;
    endtask

    task automatic applyStimulus(input int prescale, input int dataBits, input int parity, input int twoStop);
        pushExpected(prescale, dataBits, parity, twoStop, -1);
        pulseStart(prescale, dataBits, parity, twoStop);
    endtask

    task automatic waitIdle(input string name, input int maxCycles);
        int n;
        n = 0;
        while (o_busy && n < maxCycles) begin
            step();
            n++;
        end
        if (o_busy) checkOutput({name, "_idle_timeout"}, 1, 0);
    endtask

    task automatic waitCount(input string name, input int b, input int e, input int maxCycles);
        int n;
        n = 0;
        while (!(int'(o_bit_count) == b && int'(o_edge_count) == e) && n < maxCycles) begin
            step();
            n++;
        end
        if (!(int'(o_bit_count) == b && int'(o_edge_count) == e))
            checkOutput({name, "_wait_timeout"}, 0, 1);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_busy"}, int'(o_busy), 0);
        checkOutput({name, "_edge"}, int'(o_edge_count), 0);
        checkOutput({name, "_bit"}, int'(o_bit_count), 0);
    endtask

    // Monitor: track strobes within a bit, pop and compare one expectation per bit_done.
    int          sampleCount;
    int          sampleEdge;
    int          tickCount;
    int unsigned voteMask;
    exp_t        monExp;

    initial begin
        sampleCount = 0;
        sampleEdge  = 0;
        tickCount   = 0;
        voteMask    = 0;
    end

    always @(negedge i_clk) begin
        if (o_busy && i_tick) begin
            if (o_edge_count == 5'd0) begin
                sampleCount = 0;
                voteMask    = 0;
                if (o_bit_count == 4'd0) tickCount = 0;
            end
            tickCount++;
        end
        if (o_sample_strobe) begin
            sampleCount++;
            sampleEdge = int'(o_edge_count);
        end
`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
        if (o_vote_strobe) voteMask = voteMask | (32'd1 << o_edge_count);
`endif
        if (o_bit_done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_bit_done", int'(o_bit_count), -1);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("bit_index", int'(o_bit_count), monExp.bitIdx);
                checkOutput("bit_phase", int'(o_phase), monExp.phase);
                checkOutput("bit_done_edge", int'(o_edge_count), monExp.lastEdge);
                checkOutput("frame_done", int'(o_frame_done), monExp.frameDone);
                checkOutput("sample_count", sampleCount, 1);
                checkOutput("sample_edge", sampleEdge, monExp.midEdge);
`ifdef UART_RX_FRAME_TIMER_MAJORITY_EN
                checkOutput("vote_mask", int'(voteMask), int'(32'd7 << (monExp.midEdge - 1)));
`endif
                if (monExp.frameDone != 0) checkOutput("frame_ticks", tickCount, monExp.frameTicks);
            end
            sampleCount = 0;
            voteMask    = 0;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        tickPeriod  = 1;
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_prescale  = '0;
        i_data_bits = '0;
        i_parity_en = 1'b0;
        i_two_stop  = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;
        step();

        $display("[TB] reset state");
        checkIdle("reset");
        checkOutput("reset_phase", int'(o_phase), int'(PH_START));
        checkOutput("reset_sample", int'(o_sample_strobe), 0);
        checkOutput("reset_bit_done", int'(o_bit_done), 0);
        checkOutput("reset_frame_done", int'(o_frame_done), 0);

        $display("[TB] P=8 D=8 8N1, tick every cycle");
        applyStimulus(8, 8, 0, 0);
        checkOutput("t1_busy_after_start", int'(o_busy), 1);
        waitCount("t1", 9, 7, 200);
        step();
        checkIdle("t1_after_done");

        $display("[TB] P=16 D=7 parity two stop, tick every 3rd cycle");
        tickPeriod = 3;
        applyStimulus(16, 7, 1, 1);
        waitIdle("t2", 1000);
        checkOutput("t2_bits_left", expQ.size(), 0);
        tickPeriod = 1;
        step();

        $display("[TB] clamp prescale=2 data_bits=3 with parity");
        applyStimulus(2, 3, 1, 0);
        waitIdle("t3", 100);
        checkOutput("t3_bits_left", expQ.size(), 0);

        $display("[TB] abort at bit 3 edge 5");
        pushExpected(8, 8, 0, 0, 3);
        pulseStart(8, 8, 0, 0);
        waitCount("t4", 3, 5, 100);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        checkIdle("t4_abort");
        repeat (10) step();
        checkOutput("t4_bits_left", expQ.size(), 0);

        $display("[TB] start with abort in RUN and in IDLE");
        pushExpected(8, 8, 0, 0, 1);
        pulseStart(8, 8, 0, 0);
        waitCount("t5", 1, 2, 50);
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        checkIdle("t5_run");
        i_start = 1'b1;
        i_abort = 1'b1;
        step();
        i_start = 1'b0;
        i_abort = 1'b0;
        checkIdle("t5_idle");
        checkOutput("t5_bits_left", expQ.size(), 0);

        $display("[TB] restart on frame_done");
        pushExpected(8, 5, 0, 0, -1);
        pushExpected(4, 6, 0, 1, -1);
        pulseStart(8, 5, 0, 0);
        waitCount("t6", 6, 7, 100);
        pulseStart(4, 6, 0, 1);
        checkOutput("t6_busy", int'(o_busy), 1);
        checkOutput("t6_bit", int'(o_bit_count), 0);
        checkOutput("t6_edge", int'(o_edge_count), 0);
        waitIdle("t6", 100);
        checkOutput("t6_bits_left", expQ.size(), 0);

        $display("[TB] reset mid-frame at bit 4");
        pushExpected(8, 8, 0, 0, 4);
        pulseStart(8, 8, 0, 0);
        waitCount("t7", 4, 0, 100);
        i_rst = 1'b1;
        step();
        checkIdle("t7_reset");
        checkOutput("t7_phase", int'(o_phase), int'(PH_START));
        checkOutput("t7_sample", int'(o_sample_strobe), 0);
        checkOutput("t7_bit_done", int'(o_bit_done), 0);
        checkOutput("t7_frame_done", int'(o_frame_done), 0);
        i_rst = 1'b0;
        repeat (5) step();
        checkOutput("t7_bits_left", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_timer.md
Name: uart_rx_frame_timer

Overview:
- Parametrised successor to the UART RX edge/bit counter.
- Counts oversampling ticks within each bit and bits within a frame.
- Frame shape is run-time programmable: data bits, parity, stop bits. Prescale is also run-time programmable.
- Produces mid-bit sample strobes, bit-end strobes, frame-phase decode and a frame-done pulse for the RX FSM and sampler.

Parameters:
- PRESCALE_MAX, 32, largest legal oversampling ratio.
- DATA_WIDTH_MAX, 8, largest legal data-bit count.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_tick  in  1  oversample tick; counters advance only when high.
- i_start  in  1  pulse; begin or restart frame timing.
- i_abort  in  1  pulse; drop the current frame (false start or error).
- i_prescale  in  $clog2(PRESCALE_MAX)+1  ticks per bit; latched at start.
- i_data_bits  in  $clog2(DATA_WIDTH_MAX+1)  data bits per frame; latched at start.
- i_parity_en  in  1  frame carries a parity bit; latched at start.
- i_two_stop  in  1  frame carries two stop bits; latched at start.
- o_busy  out  1  frame timing active.
- o_edge_count  out  $clog2(PRESCALE_MAX)  tick index within the current bit.
- o_bit_count  out  $clog2(DATA_WIDTH_MAX+4)  bit index within the frame.
- o_phase  out  2  current bit type: START / DATA / PARITY / STOP.
- o_sample_strobe  out  1  mid-bit sample point.
- o_bit_done  out  1  last tick of the current bit.
- o_frame_done  out  1  last tick of the last stop bit.

Behaviour:
- Reset:
  - i_rst sampled high at a clock edge clears all registers.
  - Outputs after reset: busy=0, edge_count=0, bit_count=0, phase=START; all strobes 0.
  - Reset dominates start and abort, and takes effect mid-frame.
- States: IDLE (busy=0) and RUN (busy=1).
- Configuration latching:
  - On i_start, P, D, parity flag and stop count are latched into shadow registers.
  - Input changes during RUN are ignored.
- Clamping:
  - P below 4 is clamped to 4; above PRESCALE_MAX, clamped to PRESCALE_MAX.
  - D below 5 is clamped to 5; above DATA_WIDTH_MAX, clamped to DATA_WIDTH_MAX.
- Frame length:
  - L = 1 + D + parity_en + (two_stop ? 2 : 1).
- IDLE to RUN:
  - Triggered by i_start (no tick required).
  - On the next cycle: busy=1, edge_count=0, bit_count=0.
- Counting in RUN:
  - On a cycle with i_tick=1, edge_count increments.
  - If edge_count==P-1, edge_count wraps to 0 and bit_count increments.
  - Without i_tick, counters hold.
- Strobes:
  - Decoded combinationally from registered counters and i_tick; high only when busy=1 and i_tick=1.
  - o_sample_strobe: edge_count==P>>1.
  - o_bit_done: edge_count==P-1.
  - o_frame_done: o_bit_done and bit_count==L-1.
  - Each strobe fires exactly once per bit (frame_done once per frame).
- End of frame: the tick that raises o_frame_done returns the block to IDLE next cycle, with counters cleared.
- Phase decode (from bit_count):
  - 0 is START.
  - 1..D is DATA.
  - D+1 is PARITY when enabled.
  - Remaining indices are STOP.
- i_start in RUN: restarts at bit 0 / edge 0 with newly latched configuration. No frame_done for the dropped frame.
- i_abort in RUN: returns to IDLE next cycle with counters cleared. In IDLE it has no effect.
- i_abort and i_start together: abort wins; the block ends in IDLE.
- i_start on the o_frame_done cycle: restart wins; the block is busy on the next cycle with bit 0, edge 0 (back-to-back frames).
- Width rule: counters never exceed P-1 / L-1. All comparisons are made at counter width, zero-extended.

Optional Feature:
- Macro: UART_RX_FRAME_TIMER_MAJORITY_EN.
- When defined:
  - Adds output o_vote_strobe (1 bit).
  - High with busy and i_tick at edge_count P/2-1, P/2 and P/2+1, so the sampler can take a 3-sample majority vote.
  - o_sample_strobe keeps its meaning.
- When undefined: the port and its logic are absent.

Decomposition:
- Package uart_rx_pkg holds:
  - the phase enum (PH_START=0, PH_DATA=1, PH_PARITY=2, PH_STOP=3);
  - the constants MIN_PRESCALE=4 and MIN_DATA_BITS=5;
  - a function computing frame length.
- One natural sub-module, uart_rx_cfg_latch: clamps and latches P, D and frame length on start.

Test Plan:
- P=8, D=8, no parity, one stop, i_tick every cycle, one i_start:
  - sample strobes at edge 4 of bits 0..9;
  - o_frame_done on cycle 80 after start;
  - busy low on the next cycle.
- P=16, D=7, parity on, two stops, i_tick every 3rd cycle:
  - L=11;
  - PARITY phase at bit 8, STOP at bits 9..10;
  - exactly 11 o_bit_done pulses.
- i_prescale=2, i_data_bits=3:
  - behaves as P=4, D=5;
  - sample strobe at edge 2;
  - frame_done after 32 ticks.
- i_abort at bit 3, edge 5:
  - busy=0 next cycle, counters 0, no frame_done.
  - Repeat with i_start and i_abort asserted together: IDLE results.
- i_start asserted on the frame_done cycle, and i_rst at mid-frame bit 4:
  - start case: busy stays 1, bit_count=0, edge_count=0;
  - reset case: all outputs zero next cycle.
- With UART_RX_FRAME_TIMER_MAJORITY_EN defined and P=8: o_vote_strobe at edges 3, 4 and 5 of every bit.
